// File: rtl/seq_mult_pkg.sv
// Shared constants and state encoding for the iterative shift-add multiplier.
package seq_mult_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  // 2'd3 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_add_2w.sv
// Combinational W-bit carry-select adder: ripple low half, upper half
// precomputed for both carry-ins and selected by the low-half carry.
module mult_add_2w #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  localparam int LO = W / 2;
  localparam int HI = W - LO;

  logic [LO:0] lo_s;
  logic [HI:0] hi_s0;
  logic [HI:0] hi_s1;

  assign lo_s  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, c_in};
  assign hi_s0 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
  assign hi_s1 = hi_s0 + {{HI{1'b0}}, 1'b1};

  assign {c_out, sum} = {(lo_s[LO] ? hi_s1 : hi_s0), lo_s[LO-1:0]};

endmodule

// File: rtl/seq_mult_32bit.sv
// Iterative shift-add unsigned multiplier, one 2*WIDTH-bit add per cycle.
// Optional SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
module seq_mult_32bit
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  state_t             state, state_n;
  logic [PW-1:0]      mcand;
  logic [WIDTH-1:0]   mplier;
  logic [PW-1:0]      acc;
  logic [PW-1:0]      acc_n;
  logic [CNT_W-1:0]   count;
  logic [PW-1:0]      sum;
  logic               carry_unused;
  logic               last;

  // Carry out cannot be set: acc + mcand stays below 2^PW for in-range operands.
  mult_add_2w #(.W(PW)) u_add (
    .a     (acc),
    .b     (mcand),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (carry_unused)
  );

  assign acc_n = mplier[0] ? sum : acc;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign last = (count == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
  assign last = (count == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          acc    <= '0;
          count  <= '0;
        end
        RUN: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (last) product <= acc_n;
          else      count   <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_32bit.sv
// Directed and random checks of seq_mult_32bit, with or without SEQ_MULT_EARLY_EXIT_EN.
module tb_seq_mult_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int tests = 0;
  int fails = 0;

  seq_mult_32bit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] y);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < 32; i++) if (y[i]) m = i;
    return m + 2;
`else
    return 33;
`endif
  endfunction

  // Adder carry-out must stay low on every RUN cycle.
  always @(negedge clk) begin
    if (!reset && busy && !done) begin
      tests++;
      assert (dut.u_add.c_out === 1'b0) else begin
        fails++;
        $error("FAIL c_out: got %0b expected 0", dut.u_add.c_out);
      end
    end
  end

  // Waits (bounded) for done; lat counts busy cycles including the done cycle.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy) lat++;
      if (done) break;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] p, output int lat);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    wait_done(lat);
    p = product;
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] x, y;
    int lat, rst_at;
    bit saw_done;

    reset = 1'b1; start = 1'b1; a = 32'd3; b = 32'd5;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", product, 64'd0);
    reset = 1'b0; start = 1'b0;

    run_op(32'd3, 32'd5, p, lat);
    chk("3x5", p, 64'd15);
    chk("3x5_lat", 64'(lat), 64'(exp_lat(32'd5)));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("held_product", product, 64'd15);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, p, lat);
    chk("max_x_max", p, 64'hFFFFFFFE00000001);
    chk("max_lat", 64'(lat), 64'(exp_lat(32'hFFFFFFFF)));

    run_op(32'h12345678, 32'd0, p, lat);
    chk("x_zero", p, 64'd0);
    chk("zero_lat", 64'(lat), 64'(exp_lat(32'd0)));

    // start held through the whole op; second request must be ignored
    @(negedge clk);
    a = 32'd2; b = 32'd9; start = 1'b1;
    @(negedge clk);
    a = 32'd7; b = 32'd7;
    wait_done(lat);
    chk("2x9_ignore", product, 64'd18);
    chk("2x9_lat", 64'(lat), 64'(exp_lat(32'd9)));
    @(negedge clk);
    chk("idle_after_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("b2b_accept", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(lat);
    chk("7x7", product, 64'd49);

    // reset mid-run aborts without a done pulse
`ifdef SEQ_MULT_EARLY_EXIT_EN
    rst_at = 3;
`else
    rst_at = 10;
`endif
    @(negedge clk);
    @(negedge clk);
    a = 32'd100; b = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0; saw_done = 1'b0;
    for (int i = 1; i < rst_at; i++) begin
      saw_done |= done;
      @(negedge clk);
    end
    saw_done |= done;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done || saw_done), 64'd0);
    chk("abort_product", product, 64'd0);
    run_op(32'd100, 32'd100, p, lat);
    chk("100x100", p, 64'd10000);

    for (int n = 0; n < 1000; n++) begin
      x = $urandom;
      y = $urandom;
      if (n % 4 == 1) y = y >> $urandom_range(31, 0);
      if (n % 4 == 2) x = x >> $urandom_range(31, 0);
      run_op(x, y, p, lat);
      chk("rand_prod", p, {32'd0, x} * {32'd0, y});
      chk("rand_lat", 64'(lat), 64'(exp_lat(y)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
